sr_latch_driver: RTL and testbench
==================================

Name: sr_latch_driver

Overview:
- Clocked controller that drives the r/s inputs of a cross-coupled NOR SR latch with set/reset commands.
- Each accepted command produces exactly one pulse, `s` for set or `r` for reset, of fixed width, followed by a dead gap.
- At the end of the gap it reads back the latch outputs through a synchronizer and raises a sticky error flag on mismatch.
- It sits between command logic (req/ack handshake) and the latch, and guarantees the latch never sees the forbidden r=s=1 input.

Parameters:
- PW, 4: pulse width in clock cycles; legal range 1..15.
- GAP, 2: dead cycles with r=s=0 after each pulse; legal range 2..15. The minimum of 2 covers synchronizer latency.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  1  command request; sampled only in IDLE.
- cmd  input  1  command; 1 = set (target qa=1, qb=0), 0 = reset (target qa=0, qb=1). Sampled together with req.
- ack  output  1  one-cycle pulse confirming that a command was accepted.
- busy  output  1  high while a command is in progress (PULSE or GAP).
- r  output  1  latch reset input; registered.
- s  output  1  latch set input; registered.
- qa  input  1  latch output; asynchronous, so it passes through a 2-flop synchronizer.
- qb  input  1  complementary latch output; asynchronous, 2-flop synchronizer.
- q  output  1  shadow of the last commanded latch state.
- err  output  1  sticky readback-mismatch flag.

Behaviour:
- Reset (rst_n=0):
  - Takes effect immediately, without waiting for clk.
  - Forces state=IDLE and r=s=ack=busy=q=err=0.
  - Clears the counter and the synchronizer flops.
  - Reset in the middle of a pulse drops r/s at once. The latch keeps whatever state it reached; q reads 0 regardless.
- FSM states: IDLE, PULSE, GAP. A counter of width 4 counts cycles within PULSE and GAP.
- IDLE:
  - r=s=0, busy=0.
  - On an edge with req=1: capture cmd, load counter with PW-1, go to PULSE.
  - On that same edge register ack=1, busy=1, s=cmd, r=~cmd.
- ack is high for exactly the one cycle after the accepting edge, then returns to 0.
- PULSE:
  - Holds s/r for exactly PW cycles.
  - On the edge where counter=0: r=s=0, load counter with GAP-1, go to GAP.
- GAP:
  - Holds r=s=0 for GAP cycles.
  - On the edge where counter=0, compare the synchronized {qa,qb} against {cmd_captured, ~cmd_captured}:
    - If they differ, set err=1.
    - In either case q<=cmd_captured, busy<=0, next state IDLE.
- Timing:
  - If the accepting edge is k, busy is high from k to k+PW+GAP, i.e. PW+GAP cycles.
  - The earliest next acceptance is at edge k+PW+GAP+1. Back-to-back command period = PW+GAP+1 cycles.
- req while busy: ignored. No ack, no queueing, and captured cmd is unchanged. cmd changes after acceptance have no effect.
- Redundant command (cmd equals current q): a full pulse, gap and check are still performed.
- Invariants:
  - r and s are never both 1, in any cycle or under any reset sequence.
  - r and s change only on clock edges or on asynchronous reset assertion.
- err is sticky: once set, it stays 1 through later successful commands and is cleared only by rst_n=0.
- Synchronizer sampling is valid because PW>=1 and GAP>=2. By the check edge the synchronized values reflect a latch that settled at least 2 edges earlier.

Test Plan:
All scenarios use PW=4, GAP=2 with the NOR latch model wired as qa=~(r|qb), qb=~(s|qa).
- Reset: rst_n=0 for 3 cycles, then release with req=0. Required: r=s=ack=busy=q=err=0; no activity.
- Set: req=1, cmd=1 for one edge. Required: ack=1 for 1 cycle; s=1 for exactly 4 cycles with r=0; busy=1 for 6 cycles; afterwards q=1, err=0, and latch shows qa=1, qb=0.
- Reset command after set: req=1, cmd=0. Required: r=1 for 4 cycles with s=0; then q=0, latch shows qa=0, qb=1, err=0. Total period from the first accepting edge to the next accepting edge is 7 cycles.
- Request while busy: second req=1, cmd=0 pulsed in the 2nd cycle of a set pulse. Required: no ack, s stays 1 for the full 4 cycles, r stays 0, and q ends at 1.
- Readback fault: bench overrides qa=0, qb=0 during a set command. Required: err=1 after the check edge while q=1. err stays 1 through two further good commands and clears only on rst_n=0.
- Reset mid-pulse: assert rst_n=0 between edges in the 2nd cycle of PULSE. Required: s falls to 0 before the next clk edge; busy=0, q=0. After release a new req=1, cmd=1 is accepted normally with ack. A checker asserts r&s==0 in every cycle of every test.

Source files
------------

// File: rtl/sr_latch_driver_if.sv
// Command handshake between the issuing logic and the SR latch driver.
// The master raises req with cmd; the slave answers with ack and busy.
interface sr_latch_driver_if;
    logic req;
    logic cmd;
    logic ack;
    logic busy;

    modport master (
        output req,
        output cmd,
        input  ack,
        input  busy
    );

    modport slave (
        input  req,
        input  cmd,
        output ack,
        output busy
    );
endinterface

// File: rtl/sr_latch_driver.sv
// Drives r/s of a cross-coupled NOR SR latch with fixed-width pulses and a dead gap,
// then checks the synchronized latch outputs against the commanded state.
module sr_latch_driver #(
    parameter int PW  = 4,
    parameter int GAP = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_latch_driver_if.slave   cmd_if,
    output logic               r,
    output logic               s,
    input  logic               qa,
    input  logic               qb,
    output logic               q,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP_S = 2'd2
    } state_t;

    localparam logic [3:0] PW_LD  = 4'(PW - 1);
    localparam logic [3:0] GAP_LD = 4'(GAP - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       cmd_q, cmd_d;
    logic       ack_q, ack_d;
    logic       busy_q, busy_d;
    logic       r_q, r_d;
    logic       s_q, s_d;
    logic       q_q, q_d;
    logic       err_q, err_d;
    logic       qa_meta_q, qa_sync_q;
    logic       qb_meta_q, qb_sync_q;

    // State, counter, registered outputs and readback synchronizers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            cmd_q     <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            r_q       <= 1'b0;
            s_q       <= 1'b0;
            q_q       <= 1'b0;
            err_q     <= 1'b0;
            qa_meta_q <= 1'b0;
            qa_sync_q <= 1'b0;
            qb_meta_q <= 1'b0;
            qb_sync_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            r_q       <= r_d;
            s_q       <= s_d;
            q_q       <= q_d;
            err_q     <= err_d;
            qa_meta_q <= qa;
            qa_sync_q <= qa_meta_q;
            qb_meta_q <= qb;
            qb_sync_q <= qb_meta_q;
        end
    end

    // Next state, cycle counter and command capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        case (state_q)
            IDLE: begin
                if (cmd_if.req) begin
                    state_d = PULSE;
                    cnt_d   = PW_LD;
                    cmd_d   = cmd_if.cmd;
                end else begin
                    cnt_d   = 4'd0;
                end
            end
            PULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = GAP_S;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            GAP_S: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Next values of the registered outputs; s and r derive from one bit so they stay exclusive
    always_comb begin
        ack_d  = 1'b0;
        busy_d = busy_q;
        r_d    = 1'b0;
        s_d    = 1'b0;
        q_d    = q_q;
        err_d  = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_if.req) begin
                    ack_d  = 1'b1;
                    busy_d = 1'b1;
                    s_d    = cmd_if.cmd;
                    r_d    = ~cmd_if.cmd;
                end else begin
                    busy_d = 1'b0;
                end
            end
            PULSE: begin
                busy_d = 1'b1;
                if (cnt_q != 4'd0) begin
                    s_d = cmd_q;
                    r_d = ~cmd_q;
                end else begin
                    s_d = 1'b0;
                    r_d = 1'b0;
                end
            end
            GAP_S: begin
                if (cnt_q == 4'd0) begin
                    busy_d = 1'b0;
                    q_d    = cmd_q;
                    if ({qa_sync_q, qb_sync_q} != {cmd_q, ~cmd_q}) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign cmd_if.ack  = ack_q;
    assign cmd_if.busy = busy_q;
    assign r           = r_q;
    assign s           = s_q;
    assign q           = q_q;
    assign err         = err_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: a behavioural NOR latch, queued expectations per command,
// and a negedge monitor that scores each completed command.
module tb_sr_latch_driver;

    localparam int PW  = 4;
    localparam int GAP = 2;

    typedef struct packed {
        logic cmd;
        logic q;
        logic err;
        logic qa;
        logic qb;
        logic aborted;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic r, s, qa, qb, q, err;
    logic fault = 1'b0;
    logic latch_st = 1'b0;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    int ack_cyc[$];
    int ncyc = 0;

    sr_latch_driver_if bus ();

    sr_latch_driver #(.PW(PW), .GAP(GAP)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cmd_if (bus.slave),
        .r      (r),
        .s      (s),
        .qa     (qa),
        .qb     (qb),
        .q      (q),
        .err    (err)
    );

    always #5 clk = ~clk;

    // NOR latch: s sets, r resets, holds otherwise (r=s=1 never occurs legally)
    always @(posedge s or posedge r) begin
        if (s) latch_st <= 1'b1;
        else   latch_st <= 1'b0;
    end

    assign qa = fault ? 1'b0 : latch_st;
    assign qb = fault ? 1'b0 : ~latch_st;

    task automatic chk(input string name, input int act, input int req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req_v);
        end
    endtask

    function automatic exp_t mk(input logic c, input logic eq, input logic ee,
                                input logic ea, input logic eb, input logic ab);
        exp_t e;
        e.cmd = c; e.q = eq; e.err = ee; e.qa = ea; e.qb = eb; e.aborted = ab;
        return e;
    endfunction

    // Monitor: opens a transaction on ack, scores it when busy drops
    initial begin : monitor
        exp_t cur;
        bit   in_txn;
        int   s_cnt, r_cnt, b_cnt, a_cnt;
        in_txn = 1'b0;
        s_cnt = 0; r_cnt = 0; b_cnt = 0; a_cnt = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            chk("r_s_exclusive", int'(r & s), 0);
            if (!rst_n) begin
                if (in_txn) begin
                    chk("abort_expected", int'(cur.aborted), 1);
                    in_txn = 1'b0;
                end
            end else begin
                if (bus.ack && !in_txn) begin
                    ack_cyc.push_back(ncyc);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        in_txn = 1'b1;
                        s_cnt = 0; r_cnt = 0; b_cnt = 0; a_cnt = 0;
                    end
                end
                if (in_txn) begin
                    if (bus.ack) a_cnt++;
                    if (s) s_cnt++;
                    if (r) r_cnt++;
                    if (bus.busy) begin
                        b_cnt++;
                    end else begin
                        chk("aborted_completed", int'(cur.aborted), 0);
                        chk("ack_cycles", a_cnt, 1);
                        chk("s_cycles", s_cnt, cur.cmd ? PW : 0);
                        chk("r_cycles", r_cnt, cur.cmd ? 0 : PW);
                        chk("busy_cycles", b_cnt, PW + GAP);
                        chk("q_after", int'(q), int'(cur.q));
                        chk("err_after", int'(err), int'(cur.err));
                        chk("latch_qa", int'(qa), int'(cur.qa));
                        chk("latch_qb", int'(qb), int'(cur.qb));
                        in_txn = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (!bus.busy) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_ack(input string name);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.ack) return;
        end
        chk(name, 1, 0);
    endtask

    task automatic issue(input exp_t e);
        @(negedge clk);
        bus.req = 1'b1;
        bus.cmd = e.cmd;
        exp_q.push_back(e);
        @(negedge clk);
        bus.req = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_r"}, int'(r), 0);
        chk({tag, "_s"}, int'(s), 0);
        chk({tag, "_ack"}, int'(bus.ack), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_q"}, int'(q), 0);
        chk({tag, "_err"}, int'(err), 0);
    endtask

    initial begin : stim
        bus.req = 1'b0;
        bus.cmd = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("after_reset");

        // Set then reset with req held high: period between accepts must be PW+GAP+1
        @(negedge clk);
        bus.req = 1'b1;
        bus.cmd = 1'b1;
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        wait_ack("ack1_timeout");
        bus.cmd = 1'b0;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        wait_ack("ack2_timeout");
        @(negedge clk);
        bus.req = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        if (ack_cyc.size() >= 2)
            chk("accept_period", ack_cyc[ack_cyc.size()-1] - ack_cyc[ack_cyc.size()-2], PW + GAP + 1);
        else
            chk("accept_count", ack_cyc.size(), 2);

        // Request during pulse is ignored
        issue(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        bus.req = 1'b1;
        bus.cmd = 1'b0;
        @(negedge clk);
        bus.req = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        // Readback fault sets sticky err
        fault = 1'b1;
        issue(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        wait_idle();
        repeat (2) @(negedge clk);
        fault = 1'b0;
        issue(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        wait_idle();
        issue(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        wait_idle();
        repeat (2) @(negedge clk);
        chk("err_sticky", int'(err), 1);
        rst_n = 1'b0;
        #1;
        chk("err_cleared", int'(err), 0);
        chk("q_cleared", int'(q), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted in the second pulse cycle
        issue(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        @(posedge clk);
        #1;
        chk("s_before_abort", int'(s), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_s", int'(s), 0);
        chk("abort_r", int'(r), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_q", int'(q), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
